lsu_align: RTL and testbench

LSU_ALIGN -- requirements
Module: lsu_align

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_lane_ext.sv | 68 ++++++
 rtl/lsu_align.sv | 149 ++++++++++++++
 tb/tb_lsu_align.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - op codes, FSM states and access-size helper for lsu_align
package lsu_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_D  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_CAPT   = 3'd2,
    ST_ISSUE2 = 3'd3,
    ST_CAPT2  = 3'd4,
    ST_RSP    = 3'd5
  } lsu_state_e;

  function automatic logic [3:0] op_size(input logic [2:0] op);
    logic [3:0] sz;
    case (op)
      OP_B, OP_BU: sz = 4'd1;
      OP_H, OP_HU: sz = 4'd2;
      OP_W:        sz = 4'd4;
      OP_D:        sz = 4'd8;
      default:     sz = 4'd1;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_lane_ext.sv
// rtl/lsu_lane_ext.sv - combinational lane steering for stores and shift/extend for loads
// Two-word (lo/hi) view so that word-crossing accesses use the same shifters.
module lsu_lane_ext
  import lsu_pkg::*;
#(
  parameter int DW = 32,
  localparam int NB = DW / 8,
  localparam int LW = $clog2(NB)
) (
  input  logic [2:0]    op_i,
  input  logic [LW-1:0] off_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [DW-1:0] rdata_lo_i,
  input  logic [DW-1:0] rdata_hi_i,
  output logic [NB-1:0] be_lo_o,
  output logic [NB-1:0] be_hi_o,
  output logic [DW-1:0] wdata_lo_o,
  output logic [DW-1:0] wdata_hi_o,
  output logic [DW-1:0] rdata_o
);

  logic [3:0]      size;
  logic [NB-1:0]   lane_mask;
  logic [DW-1:0]   wdata_m;
  logic [2*NB-1:0] be_full;
  logic [2*DW-1:0] wd_full;
  logic [2*DW-1:0] rd_full;
  logic [DW-1:0]   rd;
  logic            sign_op;
  logic            fill;

  always_comb begin
    size = op_size(op_i);
    lane_mask = '0;
    for (int i = 0; i < NB; i++) begin
      lane_mask[i] = (i < int'(size));
    end
    wdata_m = '0;
    for (int i = 0; i < DW; i++) begin
      wdata_m[i] = wdata_i[i] & lane_mask[i/8];
    end
    be_full = {{NB{1'b0}}, lane_mask} << off_i;
    wd_full = {{DW{1'b0}}, wdata_m} << {off_i, 3'b000};
    rd_full = {rdata_hi_i, rdata_lo_i} >> {off_i, 3'b000};
    rd      = rd_full[DW-1:0];
  end

  assign be_lo_o    = be_full[NB-1:0];
  assign be_hi_o    = be_full[2*NB-1:NB];
  assign wdata_lo_o = wd_full[DW-1:0];
  assign wdata_hi_o = wd_full[2*DW-1:DW];

  // B/H/W sign-extend; BU/HU zero-extend; D fills every bit so fill is unused
  always_comb begin
    sign_op = (op_i == OP_B) || (op_i == OP_H) || (op_i == OP_W);
    case (size)
      4'd1:    fill = sign_op & rd[7];
      4'd2:    fill = sign_op & rd[15];
      4'd4:    fill = sign_op & rd[31];
      default: fill = sign_op & rd[DW-1];
    endcase
    rdata_o = '0;
    for (int i = 0; i < DW; i++) begin
      rdata_o[i] = (i < 8 * int'(size)) ? rd[i] : fill;
    end
  end

endmodule

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load/store alignment unit between a request port and a word memory
// Misaligned accesses fault unless LSU_ALIGN_SPLIT_MISALIGN_EN is defined, which enables split beats.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_op_i,
  input  logic [AW-1:0]   req_addr_i,
  input  logic [DW-1:0]   req_wdata_i,
  output logic            mem_en_o,
  output logic            mem_we_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic [DW-1:0]   mem_rdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_data_o,
  output logic            rsp_exc_o
);

  localparam int NB = DW / 8;
  localparam int LW = $clog2(NB);

  lsu_state_e    state_q, state_d;
  logic [2:0]    op_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          exc_q;
  logic          split_q;
  logic [DW-1:0] rlo_q;
  logic [DW-1:0] rhi_q;

  logic [3:0]    req_size;
  logic [LW-1:0] req_off;
  logic          req_illegal;
  logic          req_mis;
  logic          req_fault;
  logic          req_split;
  logic          accept;

  always_comb begin
    req_size    = op_size(req_op_i);
    req_off     = req_addr_i[LW-1:0];
    req_illegal = (req_op_i > OP_HU) || ((req_op_i == OP_D) && (DW == 32));
    req_mis     = (4'(req_off) & (req_size - 4'd1)) != 4'd0;
`ifdef LSU_ALIGN_SPLIT_MISALIGN_EN
    req_fault   = req_illegal;
    req_split   = !req_illegal && ((5'(req_off) + 5'(req_size)) > 5'(NB));
`else
    req_fault   = req_illegal || req_mis;
    req_split   = 1'b0;
`endif
  end

  assign accept = (state_q == ST_IDLE) && req_valid_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid_i) state_d = req_fault ? ST_RSP : ST_ISSUE;
      ST_ISSUE:  state_d = ST_CAPT;
      ST_CAPT:   state_d = split_q ? ST_ISSUE2 : ST_RSP;
      ST_ISSUE2: state_d = ST_CAPT2;
      ST_CAPT2:  state_d = ST_RSP;
      ST_RSP:    if (rsp_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_B;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      exc_q   <= 1'b0;
      split_q <= 1'b0;
      rlo_q   <= '0;
      rhi_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= req_op_i;
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        exc_q   <= req_fault;
        split_q <= req_split;
        rlo_q   <= '0;
        rhi_q   <= '0;
      end
      // Capture only for loads so a store's response data stays zero
      if (state_q == ST_CAPT && !we_q) rlo_q <= mem_rdata_i;
      if (state_q == ST_CAPT2 && !we_q) rhi_q <= mem_rdata_i;
    end
  end

  logic [NB-1:0] be_lo, be_hi;
  logic [DW-1:0] wd_lo, wd_hi;
  logic [DW-1:0] ext_data;

  lsu_lane_ext #(.DW(DW)) u_lane_ext (
    .op_i       (op_q),
    .off_i      (addr_q[LW-1:0]),
    .wdata_i    (wdata_q),
    .rdata_lo_i (rlo_q),
    .rdata_hi_i (rhi_q),
    .be_lo_o    (be_lo),
    .be_hi_o    (be_hi),
    .wdata_lo_o (wd_lo),
    .wdata_hi_o (wd_hi),
    .rdata_o    (ext_data)
  );

  logic          beat2;
  logic [AW-1:0] word_addr;

  // Beat 2 address wraps naturally modulo 2^AW
  always_comb begin
    beat2       = (state_q == ST_ISSUE2);
    mem_en_o    = (state_q == ST_ISSUE) || beat2;
    word_addr   = {addr_q[AW-1:LW], {LW{1'b0}}};
    mem_we_o    = mem_en_o && we_q;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (mem_en_o) begin
      mem_addr_o = beat2 ? (word_addr + AW'(NB)) : word_addr;
      mem_be_o   = beat2 ? be_hi : be_lo;
      if (we_q) mem_wdata_o = beat2 ? wd_hi : wd_lo;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RSP);
  assign rsp_exc_o   = (state_q == ST_RSP) && exc_q;
  assign rsp_data_o  = ((state_q == ST_RSP) && !exc_q && !we_q) ? ext_data : '0;

endmodule

// File: tb/tb_lsu_align.sv
// tb/tb_lsu_align.sv - directed table-driven bench for lsu_align (DW=32 and DW=64 instances)
module tb_lsu_align;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic        req_valid32, req_ready32, req_we32;
  logic [2:0]  req_op32;
  logic [31:0] req_addr32, req_wdata32;
  logic        mem_en32, mem_we32;
  logic [3:0]  mem_be32;
  logic [31:0] mem_addr32, mem_wdata32, mem_rdata32;
  logic        rsp_valid32, rsp_ready32, rsp_exc32;
  logic [31:0] rsp_data32;

  logic        req_valid64, req_ready64, req_we64;
  logic [2:0]  req_op64;
  logic [31:0] req_addr64;
  logic [63:0] req_wdata64;
  logic        mem_en64, mem_we64;
  logic [7:0]  mem_be64;
  logic [31:0] mem_addr64;
  logic [63:0] mem_wdata64, mem_rdata64;
  logic        rsp_valid64, rsp_ready64, rsp_exc64;
  logic [63:0] rsp_data64;

  lsu_align #(.DW(32), .AW(32)) u32 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid32), .req_ready_o(req_ready32), .req_we_i(req_we32),
    .req_op_i(req_op32), .req_addr_i(req_addr32), .req_wdata_i(req_wdata32),
    .mem_en_o(mem_en32), .mem_we_o(mem_we32), .mem_be_o(mem_be32),
    .mem_addr_o(mem_addr32), .mem_wdata_o(mem_wdata32), .mem_rdata_i(mem_rdata32),
    .rsp_valid_o(rsp_valid32), .rsp_ready_i(rsp_ready32),
    .rsp_data_o(rsp_data32), .rsp_exc_o(rsp_exc32)
  );

  lsu_align #(.DW(64), .AW(32)) u64 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid64), .req_ready_o(req_ready64), .req_we_i(req_we64),
    .req_op_i(req_op64), .req_addr_i(req_addr64), .req_wdata_i(req_wdata64),
    .mem_en_o(mem_en64), .mem_we_o(mem_we64), .mem_be_o(mem_be64),
    .mem_addr_o(mem_addr64), .mem_wdata_o(mem_wdata64), .mem_rdata_i(mem_rdata64),
    .rsp_valid_o(rsp_valid64), .rsp_ready_i(rsp_ready64),
    .rsp_data_o(rsp_data64), .rsp_exc_o(rsp_exc64)
  );

  logic [31:0] mem32 [8];
  logic [63:0] mem64 [2];

  always @(posedge clk) begin
    if (mem_en32) mem_rdata32 <= mem32[mem_addr32[4:2]];
    if (mem_en64) mem_rdata64 <= mem64[mem_addr64[3]];
  end

  typedef struct {
    logic [2:0]  op;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exc;
    int          lat;
    int          nb;
    logic [31:0] a1;
    logic [3:0]  b1;
    logic [31:0] wd1;
    logic [31:0] a2;
    logic [3:0]  b2;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run32(input int idx, input vec_t v);
    int lat, nb;
    logic [31:0] a1, a2, wd1, dat;
    logic [3:0] b1, b2;
    logic we1, exc;
    bit seen;
    lat = 0; nb = 0; seen = 0;
    a1 = '0; a2 = '0; wd1 = '0; dat = '0; b1 = '0; b2 = '0; we1 = 1'b0; exc = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d.req_ready", idx), 64'(req_ready32), 64'(1));
    req_valid32 = 1'b1; req_op32 = v.op; req_we32 = v.we;
    req_addr32 = v.addr; req_wdata32 = v.wdata;
    @(posedge clk);
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) req_valid32 = 1'b0;
      if (mem_en32) begin
        nb++;
        if (nb == 1) begin a1 = mem_addr32; b1 = mem_be32; wd1 = mem_wdata32; we1 = mem_we32; end
        else begin a2 = mem_addr32; b2 = mem_be32; end
      end
      if (rsp_valid32) begin seen = 1; lat = k; dat = rsp_data32; exc = rsp_exc32; end
    end
    chk($sformatf("v%0d.latency", idx), 64'(lat), 64'(v.lat));
    chk($sformatf("v%0d.beats", idx), 64'(nb), 64'(v.nb));
    chk($sformatf("v%0d.rsp_exc", idx), 64'(exc), 64'(v.exc));
    chk($sformatf("v%0d.rsp_data", idx), 64'(dat), 64'(v.data));
    if (v.nb >= 1) begin
      chk($sformatf("v%0d.mem_addr1", idx), 64'(a1), 64'(v.a1));
      chk($sformatf("v%0d.mem_be1", idx), 64'(b1), 64'(v.b1));
      chk($sformatf("v%0d.mem_we1", idx), 64'(we1), 64'(v.we));
      if (v.we) chk($sformatf("v%0d.mem_wdata1", idx), 64'(wd1), 64'(v.wd1));
    end
    if (v.nb == 2) begin
      chk($sformatf("v%0d.mem_addr2", idx), 64'(a2), 64'(v.a2));
      chk($sformatf("v%0d.mem_be2", idx), 64'(b2), 64'(v.b2));
    end
  endtask

  task automatic run64(input string nm, input logic [2:0] op, input logic [31:0] addr,
                       input logic [7:0] eb, input logic [63:0] ed);
    int lat;
    logic [7:0] be;
    logic [31:0] ma;
    logic [63:0] dat;
    logic exc;
    bit seen;
    lat = 0; be = '0; ma = '0; dat = '0; exc = 1'b0; seen = 0;
    @(negedge clk);
    req_valid64 = 1'b1; req_op64 = op; req_we64 = 1'b0; req_addr64 = addr; req_wdata64 = '0;
    @(posedge clk);
    for (int k = 1; k <= 6 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) req_valid64 = 1'b0;
      if (mem_en64) begin be = mem_be64; ma = mem_addr64; end
      if (rsp_valid64) begin seen = 1; lat = k; dat = rsp_data64; exc = rsp_exc64; end
    end
    chk({nm, ".latency"}, 64'(lat), 64'(3));
    chk({nm, ".mem_be"}, 64'(be), 64'(eb));
    chk({nm, ".mem_addr"}, 64'(ma), 64'h8);
    chk({nm, ".rsp_data"}, dat, ed);
    chk({nm, ".rsp_exc"}, 64'(exc), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem32[i] = 32'h0;
    mem32[0] = 32'hAABB_CCDD;
    mem32[1] = 32'h1122_3344;
    mem32[4] = 32'h80FF_1234;
    mem32[7] = 32'h5566_7788;
    mem64[0] = 64'h0;
    mem64[1] = 64'h89AB_CDEF_0123_4567;

    rst = 1'b1;
    req_valid32 = 1'b0; req_we32 = 1'b0; req_op32 = '0; req_addr32 = '0; req_wdata32 = '0;
    rsp_ready32 = 1'b1;
    req_valid64 = 1'b0; req_we64 = 1'b0; req_op64 = '0; req_addr64 = '0; req_wdata64 = '0;
    rsp_ready64 = 1'b1;

    tbl.push_back('{3'd0, 1'b0, 32'h13, 32'h0, 1'b0, 3, 1, 32'h10, 4'b1000, 32'h0, 32'h0, 4'h0, 32'hFFFF_FF80});
    tbl.push_back('{3'd1, 1'b1, 32'h06, 32'h0000_BEEF, 1'b0, 3, 1, 32'h04, 4'b1100, 32'hBEEF_0000, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{3'd4, 1'b0, 32'h13, 32'h0, 1'b0, 3, 1, 32'h10, 4'b1000, 32'h0, 32'h0, 4'h0, 32'h0000_0080});
    tbl.push_back('{3'd5, 1'b0, 32'h12, 32'h0, 1'b0, 3, 1, 32'h10, 4'b1100, 32'h0, 32'h0, 4'h0, 32'h0000_80FF});
    tbl.push_back('{3'd1, 1'b0, 32'h12, 32'h0, 1'b0, 3, 1, 32'h10, 4'b1100, 32'h0, 32'h0, 4'h0, 32'hFFFF_80FF});
    tbl.push_back('{3'd2, 1'b0, 32'h10, 32'h0, 1'b0, 3, 1, 32'h10, 4'b1111, 32'h0, 32'h0, 4'h0, 32'h80FF_1234});
    tbl.push_back('{3'd2, 1'b1, 32'h00, 32'h1234_5678, 1'b0, 3, 1, 32'h00, 4'b1111, 32'h1234_5678, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{3'd0, 1'b1, 32'h01, 32'hFFFF_FFA5, 1'b0, 3, 1, 32'h00, 4'b0010, 32'h0000_A500, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{3'd7, 1'b0, 32'h10, 32'h0, 1'b1, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{3'd3, 1'b0, 32'h10, 32'h0, 1'b1, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{3'd6, 1'b1, 32'h04, 32'hFFFF_FFFF, 1'b1, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0});
`ifdef LSU_ALIGN_SPLIT_MISALIGN_EN
    tbl.push_back('{3'd2, 1'b0, 32'h03, 32'h0, 1'b0, 5, 2, 32'h00, 4'b1000, 32'h0, 32'h04, 4'b0111, 32'h2233_44AA});
    tbl.push_back('{3'd1, 1'b1, 32'h01, 32'h0000_BEEF, 1'b0, 3, 1, 32'h00, 4'b0110, 32'h00BE_EF00, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{3'd5, 1'b0, 32'h11, 32'h0, 1'b0, 3, 1, 32'h10, 4'b0110, 32'h0, 32'h0, 4'h0, 32'h0000_FF12});
    tbl.push_back('{3'd1, 1'b0, 32'h03, 32'h0, 1'b0, 5, 2, 32'h00, 4'b1000, 32'h0, 32'h04, 4'b0001, 32'h0000_44AA});
    tbl.push_back('{3'd2, 1'b0, 32'hFFFF_FFFD, 32'h0, 1'b0, 5, 2, 32'hFFFF_FFFC, 4'b1110, 32'h0, 32'h0, 4'b0001, 32'hDD55_6677});
`else
    tbl.push_back('{3'd2, 1'b0, 32'h03, 32'h0, 1'b1, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{3'd1, 1'b1, 32'h01, 32'h0000_BEEF, 1'b1, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{3'd5, 1'b0, 32'h11, 32'h0, 1'b1, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{3'd1, 1'b0, 32'h03, 32'h0, 1'b1, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0});
    tbl.push_back('{3'd2, 1'b0, 32'hFFFF_FFFD, 32'h0, 1'b1, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0});
`endif

    repeat (3) @(negedge clk);
    chk("reset.req_ready", 64'(req_ready32), 64'(1));
    chk("reset.mem_en", 64'(mem_en32), 64'(0));
    chk("reset.rsp_valid", 64'(rsp_valid32), 64'(0));
    chk("reset.mem_addr", 64'(mem_addr32), 64'(0));
    chk("reset.rsp_data", 64'(rsp_data32), 64'(0));
    rst = 1'b0;

    foreach (tbl[i]) run32(i, tbl[i]);

    // Faulting request with a stalled response: outputs must hold until handshake
    @(negedge clk);
    req_valid32 = 1'b1; req_we32 = 1'b0;
`ifdef LSU_ALIGN_SPLIT_MISALIGN_EN
    req_op32 = 3'd7; req_addr32 = 32'h10;
`else
    req_op32 = 3'd2; req_addr32 = 32'h02;
`endif
    rsp_ready32 = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) req_valid32 = 1'b0;
      chk($sformatf("stall%0d.mem_en", k), 64'(mem_en32), 64'(0));
      if (k <= 3) begin
        chk($sformatf("stall%0d.rsp_valid", k), 64'(rsp_valid32), 64'(1));
        chk($sformatf("stall%0d.rsp_exc", k), 64'(rsp_exc32), 64'(1));
        chk($sformatf("stall%0d.rsp_data", k), 64'(rsp_data32), 64'(0));
        chk($sformatf("stall%0d.req_ready", k), 64'(req_ready32), 64'(0));
        if (k == 3) rsp_ready32 = 1'b1;
      end else begin
        chk("stall.post_rsp_valid", 64'(rsp_valid32), 64'(0));
        chk("stall.post_req_ready", 64'(req_ready32), 64'(1));
      end
    end

    run64("d64.D", 3'd3, 32'h08, 8'hFF, 64'h89AB_CDEF_0123_4567);
    run64("d64.W", 3'd2, 32'h0C, 8'hF0, 64'hFFFF_FFFF_89AB_CDEF);
    run64("d64.B", 3'd0, 32'h0F, 8'h80, 64'hFFFF_FFFF_FFFF_FF89);
    run64("d64.BU", 3'd4, 32'h0F, 8'h80, 64'h0000_0000_0000_0089);

    // Reset while the load is in CAPT: access is dropped without a response
    @(negedge clk);
    req_valid32 = 1'b1; req_we32 = 1'b0; req_op32 = 3'd0; req_addr32 = 32'h13;
    @(posedge clk);
    @(negedge clk);
    req_valid32 = 1'b0;
    chk("rst_mid.issue_mem_en", 64'(mem_en32), 64'(1));
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid.mem_en", 64'(mem_en32), 64'(0));
    chk("rst_mid.rsp_valid", 64'(rsp_valid32), 64'(0));
    chk("rst_mid.mem_be", 64'(mem_be32), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid.req_ready", 64'(req_ready32), 64'(1));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_mid.no_rsp%0d", k), 64'(rsp_valid32), 64'(0));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
